// File: rtl/core_types_pkg.sv
// Shared core types: data width, canonical NOP and the fetch-buffer entry.
package core_types_pkg;
  localparam int N_BITS = 32;

  // addi x0,x0,0
  localparam logic [N_BITS-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [N_BITS-1:0] instr;
    logic [N_BITS-1:0] pc;
  } f_buf_entry_t;
endpackage

// File: rtl/F_fifo.sv
// Synchronous FIFO with flush and occupancy count; async active-high reset.
// Push while full is accepted only when a pop frees a slot in the same cycle.
module F_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/f_stage.sv
// Fetch stage: owns the fetch PC, issues tagged imem requests, buffers
// responses for decode and squashes wrong-path responses on redirect.
// Optional feature macro: F_PERF_CNT_EN adds perf_fetched / perf_squashed.
module f_stage
  import core_types_pkg::*;
#(
  parameter logic [N_BITS-1:0] RESET_PC = 32'h0000_0000,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_vld,
  input  logic              imem_req_rdy,
  output logic [N_BITS-1:0] imem_req_addr,
  input  logic              imem_rsp_vld,
  input  logic [N_BITS-1:0] imem_rsp_data,
  input  logic              redirect_vld,
  input  logic [N_BITS-1:0] redirect_tgt,
  input  logic              stall_in,
  output logic [N_BITS-1:0] nxt_instr,
  output logic [N_BITS-1:0] pc,
  output logic [N_BITS-1:0] pc_plus4,
  output logic              instr_vld
`ifdef F_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_squashed
`endif
);
  localparam int CW = $clog2(DEPTH+1);

  logic [N_BITS-1:0] fetch_pc, tag_head;
  logic [CW-1:0]     outstanding, buf_count, drop_cnt;
  logic              has_room, accept, rsp_drop, rb_push, rb_pop;
  logic              rb_empty, rb_full, tq_full, tq_empty;
  f_buf_entry_t      rb_din, rb_dout;

  // FIFO flags not needed by this stage.
  logic unused_flags;
  assign unused_flags = &{1'b0, rb_full, tq_full, tq_empty};

  // Capacity check keeps every in-flight response guaranteed a buffer slot.
  assign has_room      = ({1'b0, outstanding} + {1'b0, buf_count}) < (CW+1)'(DEPTH);
  assign imem_req_vld  = !rst && !redirect_vld && has_room;
  assign imem_req_addr = fetch_pc;
  assign accept        = imem_req_vld && imem_req_rdy;

  // A response in the redirect cycle is wrong-path by definition.
  assign rsp_drop = imem_rsp_vld && (redirect_vld || (drop_cnt != '0));
  assign rb_push  = imem_rsp_vld && !rsp_drop;
  assign rb_din   = '{instr: imem_rsp_data, pc: tag_head};

  assign instr_vld = !rb_empty && !redirect_vld;
  assign rb_pop    = instr_vld && !stall_in;
  assign nxt_instr = instr_vld ? rb_dout.instr : NOP_INSTR;
  assign pc        = instr_vld ? rb_dout.pc : '0;
  assign pc_plus4  = instr_vld ? rb_dout.pc + 32'd4 : '0;

  // Tag queue holds exactly the in-flight request PCs, so its occupancy
  // doubles as the outstanding-request counter.
  F_fifo #(.WIDTH(N_BITS), .DEPTH(DEPTH)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (imem_rsp_vld),
    .flush (1'b0),
    .din   (fetch_pc),
    .dout  (tag_head),
    .full  (tq_full),
    .empty (tq_empty),
    .count (outstanding)
  );

  F_fifo #(.WIDTH($bits(f_buf_entry_t)), .DEPTH(DEPTH)) u_rsp_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (rb_push),
    .pop   (rb_pop),
    .flush (redirect_vld),
    .din   (rb_din),
    .dout  (rb_dout),
    .full  (rb_full),
    .empty (rb_empty),
    .count (buf_count)
  );

  // Fetch PC: redirect wins, otherwise advance on each accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               fetch_pc <= RESET_PC;
    else if (redirect_vld) fetch_pc <= redirect_tgt;
    else if (accept)       fetch_pc <= fetch_pc + 32'd4;
  end

  // Drop counter: on redirect every request still in flight becomes stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    drop_cnt <= '0;
    else if (redirect_vld)                      drop_cnt <= outstanding - CW'(imem_rsp_vld);
    else if (imem_rsp_vld && (drop_cnt != '0))  drop_cnt <= drop_cnt - 1'b1;
  end

`ifdef F_PERF_CNT_EN
  // Pop and squash counters; a redirect squashes the whole buffer at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      perf_fetched  <= perf_fetched + 32'(rb_pop);
      perf_squashed <= perf_squashed + 32'(rsp_drop)
                       + (redirect_vld ? 32'(buf_count) : 32'd0);
    end
  end
`endif
endmodule

// File: tb/tb_f_stage.sv
// Randomized bench for f_stage with an in-order memory model and a
// queue-based reference of the fetch pipeline, plus directed literal pins.
module tb_f_stage;
  import core_types_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req_vld, imem_req_rdy = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_vld = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_vld = 1'b0;
  logic [31:0] redirect_tgt = '0;
  logic        stall_in = 1'b0;
  logic [31:0] nxt_instr, pc, pc_plus4;
  logic        instr_vld;
`ifdef F_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed;
`endif

  f_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_vld  (imem_req_vld),
    .imem_req_rdy  (imem_req_rdy),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_vld  (imem_rsp_vld),
    .imem_rsp_data (imem_rsp_data),
    .redirect_vld  (redirect_vld),
    .redirect_tgt  (redirect_tgt),
    .stall_in      (stall_in),
    .nxt_instr     (nxt_instr),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .instr_vld     (instr_vld)
`ifdef F_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_squashed (perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  int n_err = 0, n_chk = 0;
  longint cyc = 0;

  // memory model: in-order pending requests with their earliest return cycle
  logic [31:0] mem_q[$];
  longint      mem_t[$];
  int          lat_min = 1, lat_rand = 0;

  // reference model of the stage
  logic [31:0] m_pc;
  logic [31:0] m_inf[$];   // PCs of requests in flight
  logic [31:0] m_buf[$];   // PCs waiting for decode
  int          m_drop;
  logic [31:0] m_fet, m_sq;

  // last sampled DUT outputs for directed checks
  logic        s_req_vld, s_vld;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_drop = 0; m_fet = 0; m_sq = 0;
    m_inf.delete(); m_buf.delete(); mem_q.delete(); mem_t.delete();
  endtask

  task automatic check_reset_vals();
    chk("rst_req_vld", {31'b0, imem_req_vld}, 32'd0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_nxt_instr", nxt_instr, 32'h0000_0013);
    chk("rst_pc", pc, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'd0);
    chk("rst_instr_vld", {31'b0, instr_vld}, 32'd0);
`ifdef F_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_squashed", perf_squashed, 32'd0);
`endif
  endtask

  // Assert reset mid-cycle (asynchronous), check, then release.
  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1; imem_req_rdy = 0; stall_in = 0; redirect_vld = 0; imem_rsp_vld = 0;
    #1 check_reset_vals();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive inputs, compare against the model, advance the model.
  task automatic cycle(input bit rdy, input bit stall, input bit redir, input logic [31:0] tgt);
    bit rsp, exp_rv, exp_iv, acc;
    logic [31:0] raddr, exp_pc, t;
    longint rt;
    @(negedge clk);
    rsp   = (mem_q.size() > 0) && (mem_t[0] <= cyc);
    raddr = rsp ? mem_q[0] : 32'd0;
    imem_req_rdy  = rdy;
    stall_in      = stall;
    redirect_vld  = redir;
    redirect_tgt  = tgt;
    imem_rsp_vld  = rsp;
    imem_rsp_data = rsp ? imem_word(raddr) : $urandom();
    #1;
    exp_rv = !redir && ((m_inf.size() + m_buf.size()) < DEPTH);
    exp_iv = !redir && (m_buf.size() > 0);
    exp_pc = exp_iv ? m_buf[0] : 32'd0;
    chk("req_vld", {31'b0, imem_req_vld}, {31'b0, exp_rv});
    chk("req_addr", imem_req_addr, m_pc);
    chk("instr_vld", {31'b0, instr_vld}, {31'b0, exp_iv});
    chk("pc", pc, exp_pc);
    chk("pc_plus4", pc_plus4, exp_iv ? exp_pc + 32'd4 : 32'd0);
    chk("nxt_instr", nxt_instr, exp_iv ? imem_word(exp_pc) : NOP_INSTR);
`ifdef F_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fet);
    chk("perf_squashed", perf_squashed, m_sq);
`endif
    s_req_vld = imem_req_vld; s_addr = imem_req_addr; s_vld = instr_vld; s_pc = pc;

    acc = exp_rv && rdy;
    // memory side
    if (rsp) begin void'(mem_q.pop_front()); void'(mem_t.pop_front()); end
    if (acc) begin
      rt = cyc + lat_min + $urandom_range(0, lat_rand);
      if (mem_t.size() > 0 && rt < mem_t[$]) rt = mem_t[$];
      mem_q.push_back(m_pc); mem_t.push_back(rt);
    end
    // stage model
    if (exp_iv && !stall) begin void'(m_buf.pop_front()); m_fet++; end
    if (redir) begin m_sq += m_buf.size(); m_buf.delete(); end
    if (rsp) begin
      t = m_inf.pop_front();
      if (redir || m_drop > 0) begin
        m_sq++;
        if (!redir) m_drop--;
      end else m_buf.push_back(t);
    end
    if (redir) begin m_drop = m_inf.size(); m_pc = tgt; end
    if (acc) begin m_inf.push_back(m_pc); m_pc = m_pc + 32'd4; end
    cyc++;
  endtask

  initial begin : main
    int k, nacc;
    logic [31:0] seen[$];
    model_reset();
    #1 check_reset_vals();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // straight-line fetch with a 1-cycle memory
    cycle(1, 0, 0, 0);
    chk("sl_c0_vld", {31'b0, s_req_vld}, 32'd1);
    chk("sl_c0_addr", s_addr, 32'h0);
    cycle(1, 0, 0, 0);
    chk("sl_c1_addr", s_addr, 32'h4);
    cycle(1, 0, 0, 0);
    chk("sl_c2_vld", {31'b0, s_vld}, 32'd1);
    chk("sl_c2_pc", s_pc, 32'h0);
    cycle(1, 0, 0, 0);
    chk("sl_c3_pc", s_pc, 32'h4);

    // decode stall with pc 0x8 at the head
    for (k = 0; k < 30 && !(m_buf.size() > 0 && m_buf[0] == 32'h8); k++) cycle(1, 0, 0, 0);
    if (k == 30) chk("stall_setup_timeout", 32'd0, 32'd1);
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0, 0);
      chk("stall_pc", s_pc, 32'h8);
      chk("stall_vld", {31'b0, s_vld}, 32'd1);
      if (s_req_vld) nacc++;
    end
    chk("stall_accepts_le2", {31'b0, nacc <= 2}, 32'd1);
    chk("stall_req_vld_end", {31'b0, s_req_vld}, 32'd0);
    for (k = 0; k < 30 && seen.size() < 3; k++) begin
      cycle(1, 0, 0, 0);
      if (s_vld) seen.push_back(s_pc);
    end
    if (seen.size() < 3) chk("release_timeout", 32'd0, 32'd1);
    else begin
      chk("release_pc0", seen[0], 32'h8);
      chk("release_pc1", seen[1], 32'hC);
      chk("release_pc2", seen[2], 32'h10);
    end

    // redirect with two in flight, one of them returning in the redirect cycle
    for (k = 0; k < 50 && (m_inf.size() > 0 || m_buf.size() > 0); k++) cycle(0, 0, 0, 0);
    if (k == 50) chk("drain_timeout", 32'd0, 32'd1);
    lat_min = 2;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("redir_inflight2", m_inf.size(), 32'd2);
    lat_min = 1;
    cycle(1, 0, 1, 32'h100);
    chk("redir_R_vld", {31'b0, s_vld}, 32'd0);
    chk("redir_R_req", {31'b0, s_req_vld}, 32'd0);
    cycle(1, 0, 0, 0);
    chk("redir_R1_req", {31'b0, s_req_vld}, 32'd1);
    chk("redir_R1_addr", s_addr, 32'h100);
    chk("redir_R1_vld", {31'b0, s_vld}, 32'd0);
    cycle(1, 0, 0, 0);
    chk("redir_R2_vld", {31'b0, s_vld}, 32'd0);
    cycle(1, 0, 0, 0);
    chk("redir_R3_vld", {31'b0, s_vld}, 32'd1);
    chk("redir_R3_pc", s_pc, 32'h100);

    // randomized traffic: backpressure, stalls, redirects, variable latency
    lat_rand = 2;
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, $urandom() & 32'hFFFF_FFFC);

    // asynchronous reset in the middle of traffic, then more traffic
    do_reset();
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 20) == 0, $urandom() & 32'hFFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
